// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single memory port between an instruction-fetch
// requester (IF) and a data-access requester (MA). Each access occupies the
// port for MEM_LATENCY cycles and completes with a one-cycle valid pulse.
// Optional feature: define MEM_ARB_RR_EN to alternate grants on contention;
// without it, MA always wins when both requesters are eligible.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int AW          = 16,
    parameter int DW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          ma_req,
    input  logic          ma_we,
    input  logic [AW-1:0] ma_addr,
    input  logic [DW-1:0] ma_wdata,
    output logic [DW-1:0] ma_rdata,
    output logic          ma_valid,
    output logic          ma_stall,
    output logic [AW-1:0] to_mem_addr,
    output logic [DW-1:0] core_to_mem_data,
    output logic          core_to_mem_write_enable,
    input  logic [DW-1:0] from_mem_data
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MA
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(MEM_LATENCY - 1);

    state_t        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [AW-1:0] memAddr_q, memAddr_d;
    logic [DW-1:0] memWdata_q, memWdata_d;
    logic          memWe_q, memWe_d;
    logic          isStore_q, isStore_d;
    logic [DW-1:0] ifRdata_q, ifRdata_d;
    logic [DW-1:0] maRdata_q, maRdata_d;
    logic          ifValid_q, ifValid_d;
    logic          maValid_q, maValid_d;

    logic          ifEligible;
    logic          maEligible;
    logic          pickMa;
    logic          pickIf;

`ifdef MEM_ARB_RR_EN
    logic          lastGrantMa_q, lastGrantMa_d;
`endif

    // A requester whose valid is up this cycle is still holding req from the
    // access that just finished, so it must not start a duplicate access.
    assign ifEligible = if_req & ~ifValid_q;
    assign maEligible = ma_req & ~maValid_q;

`ifdef MEM_ARB_RR_EN
    // On contention, grant whichever requester did not win the previous grant.
    assign pickMa = maEligible & (~ifEligible | ~lastGrantMa_q);
`else
    // On contention, MA always wins.
    assign pickMa = maEligible;
`endif
    assign pickIf = ifEligible & ~pickMa;

    // Grant, count down the memory latency, then capture data and pulse valid.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWe_d    = 1'b0;
        isStore_d  = isStore_q;
        ifRdata_d  = ifRdata_q;
        maRdata_d  = maRdata_q;
        ifValid_d  = 1'b0;
        maValid_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
        lastGrantMa_d = lastGrantMa_q;
`endif
        case (state_q)
            IDLE: begin
                if (pickMa) begin
                    state_d   = BUSY_MA;
                    count_d   = COUNT_INIT;
                    memAddr_d = ma_addr;
                    isStore_d = ma_we;
                    memWe_d   = ma_we;
                    if (ma_we) begin
                        memWdata_d = ma_wdata;
                    end
`ifdef MEM_ARB_RR_EN
                    lastGrantMa_d = 1'b1;
`endif
                end else if (pickIf) begin
                    state_d   = BUSY_IF;
                    count_d   = COUNT_INIT;
                    memAddr_d = if_addr;
                    isStore_d = 1'b0;
`ifdef MEM_ARB_RR_EN
                    lastGrantMa_d = 1'b0;
`endif
                end
            end
            BUSY_IF: begin
                if (count_q == 4'd0) begin
                    ifRdata_d = from_mem_data;
                    ifValid_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            BUSY_MA: begin
                if (count_q == 4'd0) begin
                    if (!isStore_q) begin
                        maRdata_d = from_mem_data;
                    end
                    maValid_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWe_q    <= 1'b0;
            isStore_q  <= 1'b0;
            ifRdata_q  <= '0;
            maRdata_q  <= '0;
            ifValid_q  <= 1'b0;
            maValid_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            lastGrantMa_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWe_q    <= memWe_d;
            isStore_q  <= isStore_d;
            ifRdata_q  <= ifRdata_d;
            maRdata_q  <= maRdata_d;
            ifValid_q  <= ifValid_d;
            maValid_q  <= maValid_d;
`ifdef MEM_ARB_RR_EN
            lastGrantMa_q <= lastGrantMa_d;
`endif
        end
    end

    assign to_mem_addr              = memAddr_q;
    assign core_to_mem_data         = memWdata_q;
    assign core_to_mem_write_enable = memWe_q;
    assign if_rdata                 = ifRdata_q;
    assign ma_rdata                 = maRdata_q;
    assign if_valid                 = ifValid_q;
    assign ma_valid                 = maValid_q;
    assign if_stall                 = if_req & ~ifValid_q;
    assign ma_stall                 = ma_req & ~maValid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Single accesses come from a vector table; contention, reissue, in-flight
// input changes and reset in the middle of a store are hand-written sequences.
// Expected completions are queued when a request is driven and popped by a
// monitor when the matching valid pulse or write strobe appears.
module tb_mem_port_arbiter;

    localparam int ML         = 2;
    localparam int WAIT_LIMIT = 40;
    localparam int NVEC       = 10;

    typedef struct {
        logic [15:0] rdata;
        int          cycle;
        bit          isStore;
    } rdExp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cycle;
    } wrExp_t;

    typedef struct {
        bit          isMa;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expRdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        ma_req;
    logic        ma_we;
    logic [15:0] ma_addr;
    logic [15:0] ma_wdata;
    logic [15:0] ma_rdata;
    logic        ma_valid;
    logic        ma_stall;
    logic [15:0] to_mem_addr;
    logic [15:0] core_to_mem_data;
    logic        core_to_mem_write_enable;
    logic [15:0] from_mem_data;

    int          cycleCnt;
    int          checks;
    int          fails;
    rdExp_t      ifQ[$];
    rdExp_t      maQ[$];
    wrExp_t      wrQ[$];
    bit [15:0]   expMaRdata;
    logic [15:0] memArr [0:255];
    bit          memReady;
    vec_t        vecs [NVEC];

    mem_port_arbiter #(
        .MEM_LATENCY(ML),
        .AW(16),
        .DW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_rdata(if_rdata),
        .if_valid(if_valid),
        .if_stall(if_stall),
        .ma_req(ma_req),
        .ma_we(ma_we),
        .ma_addr(ma_addr),
        .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata),
        .ma_valid(ma_valid),
        .ma_stall(ma_stall),
        .to_mem_addr(to_mem_addr),
        .core_to_mem_data(core_to_mem_data),
        .core_to_mem_write_enable(core_to_mem_write_enable),
        .from_mem_data(from_mem_data)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle N is the period that starts with the Nth rising edge.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Memory model: preloaded on the first edge (each word is 0xC000 | addr,
    // except 0x0010 which holds 0xBEEF), then written on every store strobe.
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 256; i++) begin
                memArr[i] <= 16'hC000 | 16'(i);
            end
            memArr[16] <= 16'hBEEF;
            memReady   <= 1'b1;
        end else if (core_to_mem_write_enable === 1'b1) begin
            memArr[to_mem_addr[7:0]] <= core_to_mem_data;
        end
    end

    assign from_mem_data = memArr[to_mem_addr[7:0]];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycleCnt);
        end
    endtask

    // Every output must be zero right after a reset with both requests low.
    task automatic checkResetState(input string tag);
        checkOutput($sformatf("%s if_valid", tag), if_valid, 0);
        checkOutput($sformatf("%s ma_valid", tag), ma_valid, 0);
        checkOutput($sformatf("%s write_enable", tag), core_to_mem_write_enable, 0);
        checkOutput($sformatf("%s to_mem_addr", tag), to_mem_addr, 0);
        checkOutput($sformatf("%s core_to_mem_data", tag), core_to_mem_data, 0);
        checkOutput($sformatf("%s if_rdata", tag), if_rdata, 0);
        checkOutput($sformatf("%s ma_rdata", tag), ma_rdata, 0);
        checkOutput($sformatf("%s if_stall", tag), if_stall, 0);
        checkOutput($sformatf("%s ma_stall", tag), ma_stall, 0);
    endtask

    // Raise one request, queue its expected completion (and write strobe for
    // a store), wait for its valid, then drop req after the valid cycle unless
    // the caller wants to reissue straight away. Call just after a rising edge.
    task automatic applyStimulus(input bit isMa, input bit we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expRdata,
                                 input int expCycle, input bit keepReq);
        rdExp_t e;
        wrExp_t w;
        int     waited;
        e.rdata   = expRdata;
        e.cycle   = expCycle;
        e.isStore = isMa & we;
        if (isMa) begin
            ma_we    = we;
            ma_addr  = addr;
            ma_wdata = wdata;
            ma_req   = 1'b1;
            maQ.push_back(e);
            if (we) begin
                w.addr  = addr;
                w.data  = wdata;
                w.cycle = expCycle - ML;
                wrQ.push_back(w);
            end
        end else begin
            if_addr = addr;
            if_req  = 1'b1;
            ifQ.push_back(e);
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (((isMa ? ma_valid : if_valid) !== 1'b1) && (waited < WAIT_LIMIT));
        checkOutput(isMa ? "ma_valid arrived" : "if_valid arrived",
                    isMa ? ma_valid : if_valid, 1);
        @(posedge clk);
        #1;
        if (!keepReq) begin
            if (isMa) begin
                ma_req = 1'b0;
            end else begin
                if_req = 1'b0;
            end
        end
    endtask

    // Monitor: stall equations every cycle, then match each valid pulse and
    // write strobe against the scoreboard; reset discards pending entries.
    always @(negedge clk) begin : monitor
        rdExp_t e;
        wrExp_t w;
        if (cycleCnt > 0) begin
            checkOutput("if_stall", if_stall, if_req & ~if_valid);
            checkOutput("ma_stall", ma_stall, ma_req & ~ma_valid);
            if (if_valid === 1'b1) begin
                if (ifQ.size() == 0) begin
                    checkOutput("if_valid unexpected", if_valid, 0);
                end else begin
                    e = ifQ.pop_front();
                    checkOutput("if_valid cycle", cycleCnt, e.cycle);
                    checkOutput("if_rdata", if_rdata, e.rdata);
                end
            end
            if (ma_valid === 1'b1) begin
                if (maQ.size() == 0) begin
                    checkOutput("ma_valid unexpected", ma_valid, 0);
                end else begin
                    e = maQ.pop_front();
                    checkOutput("ma_valid cycle", cycleCnt, e.cycle);
                    if (e.isStore) begin
                        checkOutput("ma_rdata held on store", ma_rdata, expMaRdata);
                    end else begin
                        checkOutput("ma_rdata", ma_rdata, e.rdata);
                        expMaRdata = e.rdata;
                    end
                end
            end
            if (core_to_mem_write_enable === 1'b1) begin
                if (wrQ.size() == 0) begin
                    checkOutput("write strobe unexpected", core_to_mem_write_enable, 0);
                end else begin
                    w = wrQ.pop_front();
                    checkOutput("write strobe cycle", cycleCnt, w.cycle);
                    checkOutput("write addr", to_mem_addr, w.addr);
                    checkOutput("write data", core_to_mem_data, w.data);
                end
            end
            if (rst === 1'b1) begin
                ifQ.delete();
                maQ.delete();
                wrQ.delete();
                expMaRdata = 16'h0;
            end
        end
    end

    // Test sequence.
    initial begin
        int c0;
        int ifCycle;
        int maCycle;
        wrExp_t w;

        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 16'h0;
        ma_req   = 1'b0;
        ma_we    = 1'b0;
        ma_addr  = 16'h0;
        ma_wdata = 16'h0;

        vecs[0] = '{isMa: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, expRdata: 16'hBEEF};
        vecs[1] = '{isMa: 1'b1, we: 1'b1, addr: 16'h0020, wdata: 16'h1234, expRdata: 16'h0000};
        vecs[2] = '{isMa: 1'b0, we: 1'b0, addr: 16'h0003, wdata: 16'h0000, expRdata: 16'hC003};
        vecs[3] = '{isMa: 1'b1, we: 1'b0, addr: 16'h0020, wdata: 16'h0000, expRdata: 16'h1234};
        vecs[4] = '{isMa: 1'b1, we: 1'b1, addr: 16'h0041, wdata: 16'hA5A5, expRdata: 16'h0000};
        vecs[5] = '{isMa: 1'b1, we: 1'b0, addr: 16'h0041, wdata: 16'h0000, expRdata: 16'hA5A5};
        vecs[6] = '{isMa: 1'b0, we: 1'b0, addr: 16'h0041, wdata: 16'h0000, expRdata: 16'hA5A5};
        vecs[7] = '{isMa: 1'b1, we: 1'b0, addr: 16'h00FF, wdata: 16'h0000, expRdata: 16'hC0FF};
        vecs[8] = '{isMa: 1'b1, we: 1'b1, addr: 16'h0010, wdata: 16'h0F0F, expRdata: 16'h0000};
        vecs[9] = '{isMa: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, expRdata: 16'h0F0F};

        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("power-on reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Uncontended single accesses: valid MEM_LATENCY+1 cycles after request.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].isMa, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expRdata, cycleCnt + ML + 1, 1'b0);
            @(posedge clk);
            #1;
        end

        // Both requesters raised together, last grant was IF: MA first either way.
        $display("[TB] contention after an IF grant");
        c0 = cycleCnt;
        fork
            applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0, 16'hC030, c0 + ML + 1, 1'b0);
            applyStimulus(1'b0, 1'b0, 16'h0011, 16'h0, 16'hC011, c0 + 2 * (ML + 1), 1'b0);
        join
        @(posedge clk);
        #1;

        // Both requesters hold req and reissue: grants alternate MA, IF, MA, ...
        $display("[TB] back-to-back reissue");
        c0 = cycleCnt;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    applyStimulus(1'b1, 1'b0, 16'h0060 + 16'(k), 16'h0, 16'hC060 + 16'(k),
                                  c0 + (ML + 1) + 2 * (ML + 1) * k, (k < 2));
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    applyStimulus(1'b0, 1'b0, 16'h0050 + 16'(k), 16'h0, 16'hC050 + 16'(k),
                                  c0 + 2 * (ML + 1) + 2 * (ML + 1) * k, (k < 2));
                end
            end
        join
        @(posedge clk);
        #1;

        // Lone MA access, then a tie: the policy decides who goes first.
        $display("[TB] contention after an MA grant");
        applyStimulus(1'b1, 1'b0, 16'h0061, 16'h0, 16'hC061, cycleCnt + ML + 1, 1'b0);
        @(posedge clk);
        #1;
        c0 = cycleCnt;
`ifdef MEM_ARB_RR_EN
        ifCycle = c0 + ML + 1;
        maCycle = c0 + 2 * (ML + 1);
`else
        maCycle = c0 + ML + 1;
        ifCycle = c0 + 2 * (ML + 1);
`endif
        fork
            applyStimulus(1'b1, 1'b0, 16'h0031, 16'h0, 16'hC031, maCycle, 1'b0);
            applyStimulus(1'b0, 1'b0, 16'h0012, 16'h0, 16'hC012, ifCycle, 1'b0);
        join
        @(posedge clk);
        #1;

        // Changing MA inputs while its load is in flight must not disturb it.
        $display("[TB] input change during busy");
        c0 = cycleCnt;
        fork
            applyStimulus(1'b1, 1'b0, 16'h0007, 16'h0, 16'hC007, c0 + ML + 1, 1'b0);
            begin
                @(posedge clk);
                #1;
                ma_addr  = 16'h0008;
                ma_we    = 1'b1;
                ma_wdata = 16'hFFFF;
                @(negedge clk);
                checkOutput("to_mem_addr in flight", to_mem_addr, 16'h0007);
                checkOutput("write strobe in flight", core_to_mem_write_enable, 0);
            end
        join
        ma_we = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the first BUSY_MA cycle of a store.
        $display("[TB] reset in the middle of a store");
        c0       = cycleCnt;
        ma_we    = 1'b1;
        ma_addr  = 16'h0070;
        ma_wdata = 16'h7777;
        ma_req   = 1'b1;
        w.addr   = 16'h0070;
        w.data   = 16'h7777;
        w.cycle  = c0 + 1;
        wrQ.push_back(w);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        ma_req = 1'b0;
        ma_we  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetState("mid-store reset");
        repeat (6) @(posedge clk);
        #1;

        // First contention after reset goes to MA under either policy.
        $display("[TB] contention after reset");
        c0 = cycleCnt;
        fork
            applyStimulus(1'b1, 1'b0, 16'h0032, 16'h0, 16'hC032, c0 + ML + 1, 1'b0);
            applyStimulus(1'b0, 1'b0, 16'h0013, 16'h0, 16'hC013, c0 + 2 * (ML + 1), 1'b0);
        join
        repeat (4) @(posedge clk);
        @(negedge clk);

        checkOutput("if scoreboard drained", ifQ.size(), 0);
        checkOutput("ma scoreboard drained", maQ.size(), 0);
        checkOutput("write scoreboard drained", wrQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
